// File: rtl/bmp280_i2c_target.sv
// BMP280-compatible I2C target: oversampled SCL/SDA, open-drain SDA via sda_oe.
// Define BMP280_TGT_STATUS_EN to expose measuring/im_update in the status register (0xF3).
module bmp280_i2c_target #(
  parameter logic [6:0] I2C_ADDR = 7'h76,
  parameter logic [7:0] CHIP_ID  = 8'h58
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         scl_i,
  input  logic         sda_i,
  output logic         sda_oe,
  input  logic [19:0]  temp_raw,
  input  logic [19:0]  press_raw,
  input  logic [207:0] calib_in,
  input  logic         measuring,
  output logic [7:0]   ctrl_meas,
  output logic [7:0]   config_o,
  output logic         reg_wr,
  output logic         soft_reset
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        rw_q, rw_d;
  logic [7:0]  txbyte_q, txbyte_d;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [7:0]  cfg_q, cfg_d;
  logic        reg_wr_q, reg_wr_d;
  logic        srst_q, srst_d;
  logic [19:0] temp_sh_q, temp_sh_d;
  logic [19:0] press_sh_q, press_sh_d;
  logic [2:0]  im_cnt_q, im_cnt_d;

  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;
  logic scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [7:0] byte_in_s, status_s, rd_cur_s, rd_next_s;

  // Pad synchronizers are left unreset so a reset never fabricates a START/STOP edge.
  always_ff @(posedge clk) begin
    scl_s1_q <= scl_i;
    scl_s2_q <= scl_s1_q;
    scl_h_q  <= scl_s2_q;
    sda_s1_q <= sda_i;
    sda_s2_q <= sda_s1_q;
    sda_h_q  <= sda_s2_q;
  end

  assign scl_rise_s = scl_s2_q & ~scl_h_q;
  assign scl_fall_s = ~scl_s2_q & scl_h_q;
  assign start_s    = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_s     = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign byte_in_s  = {shreg_q[6:0], sda_s2_q};

`ifdef BMP280_TGT_STATUS_EN
  assign status_s = {4'b0000, measuring, 2'b00, (im_cnt_q != 3'd0)};
`else
  logic unused_measuring_s;
  assign unused_measuring_s = measuring;
  assign status_s = 8'h00;
`endif

  function automatic logic [7:0] rd_byte(input logic [7:0] a);
    logic [4:0] idx;
    idx = a[4:0] - 5'h08;
    if (a >= 8'h88 && a <= 8'hA1) begin
      rd_byte = calib_in[{idx, 3'b000} +: 8];
    end else begin
      case (a)
        8'hD0:   rd_byte = CHIP_ID;
        8'hF3:   rd_byte = status_s;
        8'hF4:   rd_byte = ctrl_q;
        8'hF5:   rd_byte = cfg_q;
        8'hF7:   rd_byte = press_sh_q[19:12];
        8'hF8:   rd_byte = press_sh_q[11:4];
        8'hF9:   rd_byte = {press_sh_q[3:0], 4'h0};
        8'hFA:   rd_byte = temp_sh_q[19:12];
        8'hFB:   rd_byte = temp_sh_q[11:4];
        8'hFC:   rd_byte = {temp_sh_q[3:0], 4'h0};
        default: rd_byte = 8'h00;
      endcase
    end
  endfunction

  assign rd_cur_s  = rd_byte(ptr_q);
  assign rd_next_s = rd_byte(ptr_q + 8'd1);

  // Bus protocol FSM, register-write effects and read data path.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    txbyte_d   = txbyte_q;
    sda_oe_d   = sda_oe_q;
    ctrl_d     = ctrl_q;
    cfg_d      = cfg_q;
    reg_wr_d   = 1'b0;
    srst_d     = 1'b0;
    temp_sh_d  = temp_sh_q;
    press_sh_d = press_sh_q;
    im_cnt_d   = im_cnt_q;
    if (scl_rise_s && im_cnt_q != 3'd0) begin
      im_cnt_d = im_cnt_q - 3'd1;
    end else begin
      im_cnt_d = im_cnt_q;
    end
    if (stop_s) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else if (start_s) begin
      state_d  = ADDR;
      bitcnt_d = 4'd0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise_s) begin
            shreg_d  = byte_in_s;
            bitcnt_d = bitcnt_q + 4'd1;
            if (state_q == WDATA && bitcnt_q == 4'd7) begin
              if (ptr_q == 8'hF4) begin
                ctrl_d   = byte_in_s;
                reg_wr_d = 1'b1;
                if (byte_in_s[1:0] != 2'b00) im_cnt_d = 3'd4;
                else im_cnt_d = im_cnt_q;
              end else if (ptr_q == 8'hF5) begin
                cfg_d    = byte_in_s;
                reg_wr_d = 1'b1;
              end else if (ptr_q == 8'hE0 && byte_in_s == 8'hB6) begin
                srst_d = 1'b1;
                ctrl_d = 8'h00;
                cfg_d  = 8'h00;
              end else begin
                reg_wr_d = 1'b0;
              end
            end
          end else if (scl_fall_s && bitcnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            if (state_q == ADDR) begin
              if (shreg_q[7:1] == I2C_ADDR) begin
                rw_d    = shreg_q[0];
                state_d = ADDR_ACK;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = WAIT_STOP;
              end
            end else if (state_q == PTR) begin
              ptr_d   = shreg_q;
              state_d = PTR_ACK;
            end else begin
              state_d = WDATA_ACK;
            end
          end else begin
            state_d = state_q;
          end
        end
        ADDR_ACK: begin
          // Sample the raw values once per read so a burst returns a coherent set.
          if (scl_rise_s && rw_q) begin
            temp_sh_d  = temp_raw;
            press_sh_d = press_raw;
          end else if (scl_fall_s) begin
            bitcnt_d = 4'd0;
            if (rw_q) begin
              txbyte_d = rd_cur_s;
              sda_oe_d = ~rd_cur_s[7];
              state_d  = RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = PTR;
            end
          end else begin
            state_d = state_q;
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall_s) begin
            sda_oe_d = 1'b0;
            bitcnt_d = 4'd0;
            state_d  = WDATA;
            if (state_q == WDATA_ACK) ptr_d = ptr_q + 8'd1;
            else ptr_d = ptr_q;
          end else begin
            state_d = state_q;
          end
        end
        RDATA: begin
          if (scl_rise_s) begin
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall_s) begin
            if (bitcnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = RACK;
            end else begin
              txbyte_d = {txbyte_q[6:0], 1'b0};
              sda_oe_d = ~txbyte_q[6];
            end
          end else begin
            state_d = state_q;
          end
        end
        RACK: begin
          if (scl_rise_s) begin
            if (!sda_s2_q) begin
              ptr_d    = ptr_q + 8'd1;
              txbyte_d = rd_next_s;
              bitcnt_d = 4'd0;
            end else begin
              state_d = WAIT_STOP;
            end
          end else if (scl_fall_s) begin
            sda_oe_d = ~txbyte_q[7];
            state_d  = RDATA;
          end else begin
            state_d = state_q;
          end
        end
        IDLE, WAIT_STOP: state_d = state_q;
        default:         state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bitcnt_q   <= 4'd0;
      shreg_q    <= 8'h00;
      ptr_q      <= 8'h00;
      rw_q       <= 1'b0;
      txbyte_q   <= 8'h00;
      sda_oe_q   <= 1'b0;
      ctrl_q     <= 8'h00;
      cfg_q      <= 8'h00;
      reg_wr_q   <= 1'b0;
      srst_q     <= 1'b0;
      temp_sh_q  <= 20'h00000;
      press_sh_q <= 20'h00000;
      im_cnt_q   <= 3'd0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      txbyte_q   <= txbyte_d;
      sda_oe_q   <= sda_oe_d;
      ctrl_q     <= ctrl_d;
      cfg_q      <= cfg_d;
      reg_wr_q   <= reg_wr_d;
      srst_q     <= srst_d;
      temp_sh_q  <= temp_sh_d;
      press_sh_q <= press_sh_d;
      im_cnt_q   <= im_cnt_d;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign ctrl_meas  = ctrl_q;
  assign config_o   = cfg_q;
  assign reg_wr     = reg_wr_q;
  assign soft_reset = srst_q;

endmodule

// File: tb/tb_bmp280_i2c_target.sv
// Directed bit-banged I2C master bench for bmp280_i2c_target.
module tb_bmp280_i2c_target;

  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic         clk = 1'b0;
  logic         rst;
  logic         scl_m, sda_m;
  logic         sda_line;
  logic         sda_oe;
  logic [19:0]  temp_raw, press_raw;
  logic [207:0] calib_in;
  logic         measuring;
  logic [7:0]   ctrl_meas, config_v;
  logic         reg_wr, soft_reset;

  int n_cmp = 0;
  int n_err = 0;
  int reg_wr_cnt = 0;
  int srst_cnt = 0;
  int oe_cnt = 0;
  int snap;
  logic       ack_v;
  logic [7:0] rb_v;

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~sda_oe;

  bmp280_i2c_target dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
    .temp_raw(temp_raw), .press_raw(press_raw), .calib_in(calib_in),
    .measuring(measuring), .ctrl_meas(ctrl_meas), .config_o(config_v),
    .reg_wr(reg_wr), .soft_reset(soft_reset)
  );

  always @(negedge clk) begin
    if (reg_wr === 1'b1) reg_wr_cnt++;
    if (soft_reset === 1'b1) srst_cnt++;
    if (sda_oe === 1'b1) oe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wq();
      scl_m = 1'b1; wq(); wq();
      scl_m = 1'b0; wq();
    end
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    ack = sda_line; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic rd_byte(input logic master_nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wq();
      scl_m = 1'b1; wq();
      b[i] = sda_line; wq();
      scl_m = 1'b0; wq();
    end
    sda_m = master_nack; wq();
    scl_m = 1'b1; wq(); wq();
    scl_m = 1'b0; wq();
    sda_m = 1'b1;
  endtask

  initial begin
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    temp_raw = 20'h00000; press_raw = 20'hABCDE; measuring = 1'b0;
    for (int i = 0; i < 26; i++) calib_in[i*8 +: 8] = 8'h10 + 8'(i);
    repeat (10) @(negedge clk);
    chk("rst_sda_oe", 32'(sda_oe), 32'h0);
    chk("rst_ctrl_meas", 32'(ctrl_meas), 32'h00);
    chk("rst_config", 32'(config_v), 32'h00);
    chk("rst_reg_wr", 32'(reg_wr), 32'h0);
    chk("rst_soft_reset", 32'(soft_reset), 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Chip ID read through repeated START
    i2c_start(); wr_byte(8'hEC, ack_v); chk("id_ack_addr_w", 32'(ack_v), 32'h0);
    wr_byte(8'hD0, ack_v); chk("id_ack_ptr", 32'(ack_v), 32'h0);
    i2c_start(); wr_byte(8'hED, ack_v); chk("id_ack_addr_r", 32'(ack_v), 32'h0);
    rd_byte(1'b1, rb_v); chk("id_value", 32'(rb_v), 32'h58);
    i2c_stop();

    // ctrl_meas / config burst write then read back
    snap = reg_wr_cnt;
    i2c_start(); wr_byte(8'hEC, ack_v); chk("wr_ack_addr", 32'(ack_v), 32'h0);
    wr_byte(8'hF4, ack_v); chk("wr_ack_ptr", 32'(ack_v), 32'h0);
    wr_byte(8'h27, ack_v); chk("wr_ack_d0", 32'(ack_v), 32'h0);
    wr_byte(8'h00, ack_v); chk("wr_ack_d1", 32'(ack_v), 32'h0);
    i2c_stop();
    chk("wr_ctrl_meas", 32'(ctrl_meas), 32'h27);
    chk("wr_config", 32'(config_v), 32'h00);
    chk("wr_reg_wr_pulses", 32'(reg_wr_cnt - snap), 32'd2);
    i2c_start(); wr_byte(8'hEC, ack_v); wr_byte(8'hF4, ack_v);
    i2c_start(); wr_byte(8'hED, ack_v); chk("rb_ack_addr_r", 32'(ack_v), 32'h0);
    rd_byte(1'b0, rb_v); chk("rb_f4", 32'(rb_v), 32'h27);
    rd_byte(1'b1, rb_v); chk("rb_f5", 32'(rb_v), 32'h00);
    i2c_stop();

    // Temperature burst is coherent even when temp_raw changes mid-burst
    temp_raw = 20'h8A3C1;
    i2c_start(); wr_byte(8'hEC, ack_v); wr_byte(8'hFA, ack_v);
    i2c_start(); wr_byte(8'hED, ack_v);
    temp_raw = 20'h12345;
    rd_byte(1'b0, rb_v); chk("temp_fa", 32'(rb_v), 32'h8A);
    rd_byte(1'b0, rb_v); chk("temp_fb", 32'(rb_v), 32'h3C);
    rd_byte(1'b1, rb_v); chk("temp_fc", 32'(rb_v), 32'h10);
    i2c_stop();

    // Pressure burst
    i2c_start(); wr_byte(8'hEC, ack_v); wr_byte(8'hF7, ack_v);
    i2c_start(); wr_byte(8'hED, ack_v);
    rd_byte(1'b0, rb_v); chk("press_f7", 32'(rb_v), 32'hAB);
    rd_byte(1'b0, rb_v); chk("press_f8", 32'(rb_v), 32'hCD);
    rd_byte(1'b1, rb_v); chk("press_f9", 32'(rb_v), 32'hE0);
    i2c_stop();

    // Wrong address: never driven, registers untouched
    snap = oe_cnt;
    i2c_start(); wr_byte(8'hEE, ack_v); chk("bad_addr_nack", 32'(ack_v), 32'h1);
    wr_byte(8'hF4, ack_v); wr_byte(8'h55, ack_v);
    i2c_stop();
    chk("bad_addr_no_oe", 32'(oe_cnt - snap), 32'd0);
    chk("bad_addr_ctrl", 32'(ctrl_meas), 32'h27);

    // Soft reset clears ctrl_meas and config, no reg_wr pulse
    i2c_start(); wr_byte(8'hEC, ack_v); wr_byte(8'hF4, ack_v);
    wr_byte(8'h27, ack_v); wr_byte(8'hA0, ack_v); i2c_stop();
    chk("pre_srst_config", 32'(config_v), 32'hA0);
    snap = reg_wr_cnt;
    begin
      int s0;
      s0 = srst_cnt;
      i2c_start(); wr_byte(8'hEC, ack_v); wr_byte(8'hE0, ack_v);
      wr_byte(8'hB6, ack_v); chk("srst_ack", 32'(ack_v), 32'h0);
      i2c_stop();
      chk("srst_pulses", 32'(srst_cnt - s0), 32'd1);
    end
    chk("srst_ctrl", 32'(ctrl_meas), 32'h00);
    chk("srst_config", 32'(config_v), 32'h00);
    chk("srst_no_reg_wr", 32'(reg_wr_cnt - snap), 32'd0);

    // Calibration end and pointer wrap
    i2c_start(); wr_byte(8'hEC, ack_v); wr_byte(8'hA1, ack_v);
    i2c_start(); wr_byte(8'hED, ack_v);
    rd_byte(1'b0, rb_v); chk("calib_a1", 32'(rb_v), 32'h29);
    rd_byte(1'b1, rb_v); chk("calib_a2", 32'(rb_v), 32'h00);
    i2c_stop();
    i2c_start(); wr_byte(8'hEC, ack_v); wr_byte(8'h88, ack_v);
    i2c_start(); wr_byte(8'hED, ack_v);
    rd_byte(1'b1, rb_v); chk("calib_88", 32'(rb_v), 32'h10);
    i2c_stop();
    i2c_start(); wr_byte(8'hEC, ack_v); wr_byte(8'hFF, ack_v);
    i2c_start(); wr_byte(8'hED, ack_v);
    rd_byte(1'b0, rb_v); chk("wrap_ff", 32'(rb_v), 32'h00);
    rd_byte(1'b1, rb_v); chk("wrap_00", 32'(rb_v), 32'h00);
    i2c_stop();

    // Reset during a read byte releases SDA, then a fresh transaction works
    i2c_start(); wr_byte(8'hEC, ack_v); wr_byte(8'hD0, ack_v);
    i2c_start(); wr_byte(8'hED, ack_v);
    chk("mid_read_driving", 32'(sda_oe), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_read_rst_release", 32'(sda_oe), 32'h0);
    rst = 1'b0;
    i2c_stop();
    i2c_start(); wr_byte(8'hEC, ack_v); wr_byte(8'hD0, ack_v);
    i2c_start(); wr_byte(8'hED, ack_v); chk("post_rst_ack", 32'(ack_v), 32'h0);
    rd_byte(1'b1, rb_v); chk("post_rst_id", 32'(rb_v), 32'h58);
    i2c_stop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
